// File: rtl/scope_capture_ctrl_if.sv
// Handshake bundle between the sample/arm source and the capture sequencer,
// including the waveform RAM write port and capture status.
interface scope_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              trig_auto;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] start_addr;
  logic              triggered;

  modport master (
    output arm, trig_level, trig_slope, trig_auto, sample_valid, sample,
    input  wr_en, wr_addr, wr_data, busy, done, start_addr, triggered
  );

  modport slave (
    input  arm, trig_level, trig_slope, trig_auto, sample_valid, sample,
    output wr_en, wr_addr, wr_data, busy, done, start_addr, triggered
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Capture sequencer: circular pre-trigger fill, level/slope trigger (optionally forced
// by timeout), post-trigger fill, then reports the window start address with a done pulse.
module scope_capture_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PRE_TRIG = 64,
  parameter int unsigned AUTO_TO  = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  scope_capture_ctrl_if.slave  bus_io
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StPost = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [15:0] PreLast  = 16'(PRE_TRIG - 1);
  localparam logic [15:0] PostLast = 16'(DEPTH - PRE_TRIG - 2);
  localparam logic [15:0] AutoLast = 16'(AUTO_TO - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic [DATA_W-1:0] lvl_q, lvl_d;
  logic              slope_q, slope_d;
  logic              auto_q, auto_d;
  logic [ADDR_W-1:0] taddr_q, taddr_d;
  logic              tflag_q, tflag_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              trig_q, trig_d;

  logic accept, hit_rise, hit_fall, hit;

  always_comb begin
    accept   = bus_io.sample_valid &&
               (state_q == StPre || state_q == StWait || state_q == StPost);
    hit_rise = prev_ok_q && (prev_q < lvl_q) && (bus_io.sample >= lvl_q);
    hit_fall = prev_ok_q && (prev_q > lvl_q) && (bus_io.sample <= lvl_q);
    hit      = slope_q ? hit_fall : hit_rise;

    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    lvl_d     = lvl_q;
    slope_d   = slope_q;
    auto_d    = auto_q;
    taddr_d   = taddr_q;
    tflag_d   = tflag_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = start_q;
    trig_d    = trig_q;

    // busy spans the registered done pulse; arm stays blocked through it
    if (done_q) busy_d = 1'b0;

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = bus_io.sample;
      ptr_d     = ptr_q + 1'b1;
      prev_d    = bus_io.sample;
      prev_ok_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus_io.arm && !busy_q) begin
          lvl_d     = bus_io.trig_level;
          slope_d   = bus_io.trig_slope;
          auto_d    = bus_io.trig_auto;
          ptr_d     = '0;
          cnt_d     = '0;
          prev_ok_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StPre;
        end
      end
      StPre: begin
        if (accept) begin
          if (cnt_q == PreLast) begin
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StWait: begin
        if (accept) begin
          if (hit || (auto_q && cnt_q == AutoLast)) begin
            taddr_d = ptr_q;
            tflag_d = hit;
            cnt_d   = '0;
            state_d = StPost;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StPost: begin
        if (accept) begin
          if (cnt_q == PostLast) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        start_d = taddr_q - ADDR_W'(PRE_TRIG);
        trig_d  = tflag_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      lvl_q     <= '0;
      slope_q   <= 1'b0;
      auto_q    <= 1'b0;
      taddr_q   <= '0;
      tflag_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      lvl_q     <= lvl_d;
      slope_q   <= slope_d;
      auto_q    <= auto_d;
      taddr_q   <= taddr_d;
      tflag_q   <= tflag_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      trig_q    <= trig_d;
    end
  end

  assign bus_io.wr_en      = wr_en_q;
  assign bus_io.wr_addr    = wr_addr_q;
  assign bus_io.wr_data    = wr_data_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.start_addr = start_q;
  assign bus_io.triggered  = trig_q;
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: table of capture scenarios checked against a
// sample-index reference model, plus reset and initial-state sequences.
module tb_scope_capture_ctrl;
  localparam int unsigned AW = 8, DW = 8, PRE = 64, ATO = 1024, DEPTH = 256, NS = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  scope_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  scope_capture_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .PRE_TRIG(PRE), .AUTO_TO(ATO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] arr[NS];
  int exp_t, exp_total;
  bit exp_flag;

  typedef struct {
    int pat; logic [7:0] lvl; bit slope; bit am; int vprob;
    int es; int et; bit ed; int rearm_at; int budget;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int pat, int lvl, bit slope, bit am, int vp,
                              int es, int et, bit ed, int ra, int bud);
    vec_t v;
    v.pat = pat; v.lvl = 8'(lvl); v.slope = slope; v.am = am; v.vprob = vp;
    v.es = es; v.et = et; v.ed = ed; v.rearm_at = ra; v.budget = bud;
    return v;
  endfunction

  task automatic fill(input int pat);
    int w = 128;
    for (int i = 0; i < NS; i++) begin
      case (pat)
        0: arr[i] = 8'(i);
        1: arr[i] = 8'(255 - i);
        2: arr[i] = 8'd10;
        3: arr[i] = (i < 64) ? ((i % 2 == 1) ? 8'd200 : 8'd0) : 8'd10;
        4: arr[i] = 8'($urandom_range(255));
        default: begin
          w = w + int'($urandom_range(6)) - 3;
          if (w < 0) w = 0;
          if (w > 255) w = 255;
          arr[i] = 8'(w);
        end
      endcase
    end
  endtask

  // Window model by accepted-sample index: address = index mod DEPTH.
  task automatic model(input logic [7:0] lvl, input bit slope, input bit am);
    exp_t = -1; exp_flag = 0; exp_total = 0;
    for (int j = PRE; j < NS; j++) begin
      bit h;
      h = slope ? (arr[j-1] > lvl && arr[j] <= lvl) : (arr[j-1] < lvl && arr[j] >= lvl);
      if (h || (am && (j - PRE + 1) == ATO)) begin
        exp_t = j; exp_flag = h;
        exp_total = j + 1 + (DEPTH - PRE - 1);
        break;
      end
    end
  endtask

  task automatic run_capture(input vec_t v, input int id);
    int idx = 0, wcnt = 0, dcnt = 0, last_it = -10, done_it = -1;
    int exp_start;
    fill(v.pat);
    model(v.lvl, v.slope, v.am);
    exp_start = (((exp_t - PRE) % DEPTH) + DEPTH) % DEPTH;
    @(negedge clk);
    bus.arm = 1'b1; bus.trig_level = v.lvl; bus.trig_slope = v.slope; bus.trig_auto = v.am;
    bus.sample_valid = 1'b1; bus.sample = 8'hEE;  // arm-cycle sample must be dropped
    for (int it = 0; it < v.budget; it++) begin
      @(negedge clk);
      if (it == 0) check($sformatf("v%0d busy_after_arm", id), bus.busy, 1);
      if (bus.wr_en) begin
        if (exp_t < 0 || wcnt < exp_total) begin
          check($sformatf("v%0d wr_addr[%0d]", id, wcnt), bus.wr_addr, wcnt % DEPTH);
          check($sformatf("v%0d wr_data[%0d]", id, wcnt), bus.wr_data, arr[wcnt]);
        end else begin
          check($sformatf("v%0d write_count_overflow", id), wcnt + 1, exp_total);
        end
        wcnt++;
      end
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) begin
          done_it = it;
          check($sformatf("v%0d done_latency", id), it, last_it + 2);
          check($sformatf("v%0d busy_in_done", id), bus.busy, 1);
          check($sformatf("v%0d start_addr", id), bus.start_addr, exp_start);
          check($sformatf("v%0d triggered", id), bus.triggered, exp_flag);
          if (v.es >= 0) check($sformatf("v%0d start_addr_tab", id), bus.start_addr, v.es);
          if (v.et >= 0) check($sformatf("v%0d triggered_tab", id), bus.triggered, v.et);
        end
      end
      if (done_it >= 0 && it == done_it + 1)
        check($sformatf("v%0d busy_after_done", id), bus.busy, 0);
      if (done_it >= 0 && it >= done_it + 4) break;
      bus.arm = (it == v.rearm_at);
      bus.trig_level = (it == v.rearm_at) ? ~v.lvl : v.lvl;
      bus.trig_slope = (it == v.rearm_at) ? ~v.slope : v.slope;
      bus.sample_valid = ($urandom_range(99) < v.vprob);
      bus.sample = 8'hEE;
      if (bus.sample_valid && ((exp_t < 0) ? (idx < NS) : (idx < exp_total))) begin
        bus.sample = arr[idx];
        if (idx == exp_total - 1) last_it = it;
        idx++;
      end
    end
    bus.arm = 1'b0;
    check($sformatf("v%0d done_count", id), dcnt, v.ed);
    if (v.ed) check($sformatf("v%0d wr_en_pulses", id), wcnt, exp_total);
    else      check($sformatf("v%0d busy_stuck", id), bus.busy, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_en"}, bus.wr_en, 0);
    check({tag, " wr_addr"}, bus.wr_addr, 0);
    check({tag, " wr_data"}, bus.wr_data, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " done"}, bus.done, 0);
    check({tag, " start_addr"}, bus.start_addr, 0);
    check({tag, " triggered"}, bus.triggered, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arm = 1'b0; bus.trig_level = '0; bus.trig_slope = 1'b0; bus.trig_auto = 1'b0;
    bus.sample_valid = 1'b0; bus.sample = '0;

    vecs[0]  = mk(0, 100, 0, 0, 100,  36, 1, 1,  -1, 6000);
    vecs[1]  = mk(1, 128, 1, 0, 100,  63, 1, 1,  -1, 6000);
    vecs[2]  = mk(2, 100, 0, 1, 100, 255, 0, 1,  -1, 6000);
    vecs[3]  = mk(3, 100, 0, 1, 100, 255, 0, 1,  -1, 6000);
    vecs[4]  = mk(0, 100, 0, 0, 100,  36, 1, 1, 200, 6000);
    vecs[5]  = mk(0, 100, 0, 0,  50,  36, 1, 1,  -1, 6000);
    for (int i = 6; i < 10; i++)
      vecs[i] = mk((i % 2 == 0) ? 4 : 5, int'($urandom_range(255)), 1'($urandom_range(1)), 1,
                   int'($urandom_range(100, 30)), -1, -1, 1, -1, 6000);
    vecs[10] = mk(2, 100, 0, 0, 100, -1, -1, 0, -1, 5010);

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_capture(vecs[i], i);

    // vecs[10] leaves the controller waiting for a trigger; reset it mid-capture
    @(negedge clk);
    bus.sample_valid = 1'b1; bus.sample = 8'h55;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in_reset wr_en c%0d", i), bus.wr_en, 0);
      check($sformatf("in_reset busy c%0d", i), bus.busy, 0);
    end
    rst_n = 1'b1;
    bus.sample_valid = 1'b0;
    run_capture(vecs[0], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
